// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer and the ID decode that feeds it.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    HALTED   = 2'd3
  } state_t;

  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_ECALL  = OPC_SYSTEM;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET  = ctrl_t'(7'b00000_11);
  localparam ctrl_t CTRL_RUN    = ctrl_t'(7'b11111_00);
  localparam ctrl_t CTRL_FREEZE = ctrl_t'(7'b00000_00);
  localparam ctrl_t CTRL_HAZARD = ctrl_t'(7'b00111_01);
  localparam ctrl_t CTRL_BRANCH = ctrl_t'(7'b11111_10);
  localparam ctrl_t CTRL_HALT   = ctrl_t'(7'b01111_11);
  localparam ctrl_t CTRL_DRAIN  = ctrl_t'(7'b00111_01);

  function automatic logic is_ecall(input logic [6:0] opcode);
    return opcode == OPC_ECALL;
  endfunction

  function automatic logic is_branch(input logic [6:0] opcode);
    return opcode == OPC_BRANCH;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module pipeline_ctrl_sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges hazard, branch, memory-wait and halt
// events into per-stage enables/flushes, owns run/halt state and the stall statistics.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int TIMEOUT      = 64,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard,
  input  logic             branch_taken_id,
  input  logic             halt_req_id,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int WAIT_W  = $clog2(TIMEOUT + 1);
  localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

  state_t             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [DRAIN_W-1:0] drain_q, drain_d;
  logic               timeout_q, timeout_d;
  ctrl_t              ctrl;
  logic               mem_stall;
  logic               wait_hit;
  logic               count_en;

  assign mem_stall = dmem_req & ~dmem_ready;
  assign wait_hit  = (wait_q == WAIT_W'(TIMEOUT - 1));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      wait_q    <= '0;
      drain_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      drain_q   <= drain_d;
      timeout_q <= timeout_d;
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    drain_d   = drain_q;
    timeout_d = timeout_q;
    unique case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d = MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end else if (!hazard && halt_req_id) begin
          state_d = DRAIN;
          drain_d = DRAIN_W'(DRAIN_CYCLES - 1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_d = RUN;
          wait_d  = '0;
        end else if (wait_hit) begin
          timeout_d = 1'b1;
          state_d   = HALTED;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      DRAIN: begin
        // A memory stall freezes the drain countdown but still runs the timeout watchdog.
        if (mem_stall) begin
          if (wait_hit) begin
            timeout_d = 1'b1;
            state_d   = HALTED;
          end else begin
            wait_d = wait_q + 1'b1;
          end
        end else begin
          wait_d = '0;
          if (drain_q == '0) state_d = HALTED;
          else               drain_d = drain_q - 1'b1;
        end
      end
      HALTED: ;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    ctrl = CTRL_FREEZE;
    if (rst) begin
      ctrl = CTRL_RESET;
    end else begin
      unique case (state_q)
        RUN: begin
          if (mem_stall)            ctrl = CTRL_FREEZE;
          else if (hazard)          ctrl = CTRL_HAZARD;
          else if (halt_req_id)     ctrl = CTRL_HALT;
          else if (branch_taken_id) ctrl = CTRL_BRANCH;
          else                      ctrl = CTRL_RUN;
        end
        MEM_WAIT: ctrl = dmem_ready ? CTRL_RUN : CTRL_FREEZE;
        DRAIN:    ctrl = mem_stall ? CTRL_FREEZE : CTRL_DRAIN;
        HALTED:   ctrl = CTRL_FREEZE;
        default:  ctrl = CTRL_FREEZE;
      endcase
    end
  end

  assign {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush} = ctrl;

  assign count_en = ~ctrl.pc_en & ((state_q == RUN) | (state_q == MEM_WAIT));

  pipeline_ctrl_sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk   (clk),
    .clr   (rst),
    .en    (count_en),
    .count (stall_cycles)
  );

  assign halted      = (state_q == HALTED);
  assign mem_timeout = timeout_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed scoreboard bench for pipeline_ctrl (TIMEOUT=4, DRAIN_CYCLES=3, 4-bit stall counter).
module tb_pipeline_ctrl;

  localparam int CNT_W = 4;

  localparam logic [6:0] C_RST  = 7'b00000_11;
  localparam logic [6:0] C_RUN  = 7'b11111_00;
  localparam logic [6:0] C_FRZ  = 7'b00000_00;
  localparam logic [6:0] C_HAZ  = 7'b00111_01;
  localparam logic [6:0] C_BR   = 7'b11111_10;
  localparam logic [6:0] C_HLT  = 7'b00000_11;
  localparam logic [6:0] C_DRN  = 7'b00011_01;
  localparam logic [6:0] M_ALL  = 7'b11111_11;
  localparam logic [6:0] M_HLT  = 7'b10000_11;
  localparam logic [6:0] M_DRN  = 7'b11011_01;

  typedef struct {
    logic [6:0]       ctrl;
    logic [6:0]       mask;
    logic             halted;
    logic             tmo;
    logic [CNT_W-1:0] cnt;
    string            name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hazard = 1'b0, branch_taken_id = 1'b0, halt_req_id = 1'b0;
  logic dmem_req = 1'b0, dmem_ready = 1'b0;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush;
  logic halted, mem_timeout;
  logic [CNT_W-1:0] stall_cycles;

  exp_t sb[$];
  logic stim_done = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .TIMEOUT      (4),
    .DRAIN_CYCLES (3),
    .CNT_W        (CNT_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .hazard          (hazard),
    .branch_taken_id (branch_taken_id),
    .halt_req_id     (halt_req_id),
    .dmem_req        (dmem_req),
    .dmem_ready      (dmem_ready),
    .pc_en           (pc_en),
    .if_id_en        (if_id_en),
    .id_ex_en        (id_ex_en),
    .ex_mem_en       (ex_mem_en),
    .mem_wb_en       (mem_wb_en),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .halted          (halted),
    .mem_timeout     (mem_timeout),
    .stall_cycles    (stall_cycles)
  );

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %b want %b", nm, got, want);
    end
  endtask

  // One cycle of stimulus; the expected response for that cycle goes to the scoreboard.
  task automatic step(input logic r, hz, br, hl, rq, rd,
                      input logic [6:0] c, m, input logic eh, et,
                      input logic [CNT_W-1:0] ec, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; hazard = hz; branch_taken_id = br; halt_req_id = hl;
    dmem_req = rq; dmem_ready = rd;
    e.ctrl = c; e.mask = m; e.halted = eh; e.tmo = et; e.cnt = ec; e.name = nm;
    sb.push_back(e);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    step(1,0,0,0,0,0, C_RST, M_ALL, 0,0, 0, "reset");
    step(0,0,0,0,0,0, C_RUN, M_ALL, 0,0, 0, "idle");
    step(0,1,0,0,0,0, C_HAZ, M_ALL, 0,0, 0, "load_use");
    step(0,0,0,0,0,0, C_RUN, M_ALL, 0,0, 1, "after_hazard");
    step(0,0,1,0,0,0, C_BR,  M_ALL, 0,0, 1, "branch");
    step(0,1,1,0,0,0, C_HAZ, M_ALL, 0,0, 1, "branch_vs_hazard");
    step(0,0,0,0,1,0, C_FRZ, M_ALL, 0,0, 2, "mem_wait1");
    step(0,0,0,0,1,0, C_FRZ, M_ALL, 0,0, 3, "mem_wait2");
    step(0,0,0,0,1,0, C_FRZ, M_ALL, 0,0, 4, "mem_wait3");
    step(0,0,0,0,1,1, C_RUN, M_ALL, 0,0, 5, "mem_ready");
    step(0,0,0,0,0,0, C_RUN, M_ALL, 0,0, 5, "back_in_run");
    step(0,1,0,0,1,1, C_HAZ, M_ALL, 0,0, 5, "hazard_mem_hit");
    step(0,1,0,1,1,0, C_FRZ, M_ALL, 0,0, 6, "stall_beats_hazard");
    step(0,0,0,0,1,0, C_FRZ, M_ALL, 0,0, 7, "tmo_wait2");
    step(0,0,0,0,1,0, C_FRZ, M_ALL, 0,0, 8, "tmo_wait3");
    step(0,0,0,0,1,0, C_FRZ, M_ALL, 0,0, 9, "tmo_wait4");
    step(0,0,0,0,1,0, C_FRZ, M_ALL, 1,1, 10, "timed_out");
    step(0,1,1,1,1,1, C_FRZ, M_ALL, 1,1, 10, "halted_ignores");
    step(1,0,0,0,0,0, C_RST, M_ALL, 1,1, 10, "reset_from_halt");
    step(0,0,0,0,0,0, C_RUN, M_ALL, 0,0, 0, "after_reset");
    step(0,0,1,1,0,0, C_HLT, M_HLT, 0,0, 0, "halt_req");
    step(0,1,1,1,0,0, C_DRN, M_DRN, 0,0, 1, "drain0");
    step(0,0,0,0,0,0, C_DRN, M_DRN, 0,0, 1, "drain1");
    step(0,0,0,0,0,0, C_DRN, M_DRN, 0,0, 1, "drain2");
    step(0,0,0,0,0,0, C_FRZ, M_ALL, 1,0, 1, "drained");
    step(1,0,0,0,0,0, C_RST, M_ALL, 1,0, 1, "reset2");
    step(0,0,0,0,0,0, C_RUN, M_ALL, 0,0, 0, "run2");
    step(0,0,0,1,0,0, C_HLT, M_HLT, 0,0, 0, "halt_req2");
    step(0,0,0,0,0,0, C_DRN, M_DRN, 0,0, 1, "drain_a");
    step(0,0,0,0,1,0, C_FRZ, M_ALL, 0,0, 1, "drain_stall1");
    step(0,0,0,0,1,0, C_FRZ, M_ALL, 0,0, 1, "drain_stall2");
    step(0,0,0,0,0,0, C_DRN, M_DRN, 0,0, 1, "drain_b");
    step(0,0,0,0,0,0, C_DRN, M_DRN, 0,0, 1, "drain_c");
    step(0,0,0,0,0,0, C_FRZ, M_ALL, 1,0, 1, "drained_late");
    step(1,0,0,0,0,0, C_RST, M_ALL, 1,0, 1, "reset3");
    step(0,0,0,1,0,0, C_HLT, M_HLT, 0,0, 0, "halt_req3");
    step(0,0,0,0,1,0, C_FRZ, M_ALL, 0,0, 1, "drain_tmo1");
    step(0,0,0,0,1,0, C_FRZ, M_ALL, 0,0, 1, "drain_tmo2");
    step(0,0,0,0,1,0, C_FRZ, M_ALL, 0,0, 1, "drain_tmo3");
    step(0,0,0,0,1,0, C_FRZ, M_ALL, 0,0, 1, "drain_tmo4");
    step(0,0,0,0,0,0, C_FRZ, M_ALL, 1,1, 1, "drain_timed_out");
    step(1,0,0,0,0,0, C_RST, M_ALL, 1,1, 1, "reset4");
    step(0,0,0,0,1,0, C_FRZ, M_ALL, 0,0, 0, "rw_wait1");
    step(0,0,0,0,1,0, C_FRZ, M_ALL, 0,0, 1, "rw_wait2");
    step(1,0,0,0,1,0, C_RST, M_ALL, 0,0, 2, "reset_mid_wait");
    step(0,0,0,0,0,0, C_RUN, M_ALL, 0,0, 0, "run_after_rw");
    step(0,0,0,0,1,0, C_FRZ, M_ALL, 0,0, 0, "fresh_wait1");
    step(0,0,0,0,1,0, C_FRZ, M_ALL, 0,0, 1, "fresh_wait2");
    step(0,0,0,0,1,0, C_FRZ, M_ALL, 0,0, 2, "fresh_wait3");
    step(0,0,0,0,1,1, C_RUN, M_ALL, 0,0, 3, "fresh_ready");
    step(0,1,0,1,0,0, C_HAZ, M_ALL, 0,0, 3, "hazard_vs_halt");
    step(0,0,0,0,0,0, C_RUN, M_ALL, 0,0, 4, "halt_dropped");
    for (int i = 0; i < 13; i++) begin
      step(0,1,0,0,0,0, C_HAZ, M_ALL, 0,0, CNT_W'((4 + i > 15) ? 15 : 4 + i), "saturate");
    end
    step(0,0,0,0,0,0, C_RUN, M_ALL, 0,0, 15, "saturated");
    stim_done = 1'b1;
  end

  // Monitor: compares every cycle the scoreboard holds an expectation, mid-cycle on the falling edge.
  initial begin
    exp_t e;
    int   cyc;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, ".ctrl"},
              32'({pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_flush} & e.mask),
              32'(e.ctrl & e.mask));
        check({e.name, ".flags"}, 32'({halted, mem_timeout}), 32'({e.halted, e.tmo}));
        check({e.name, ".stall_cycles"}, 32'(stall_cycles), 32'(e.cnt));
      end else if (stim_done) begin
        break;
      end
      if (cyc > 2000) begin
        checks++;
        errors++;
        $display("FAIL watchdog: got %0d cycles, required stimulus to finish within 2000", cyc);
        break;
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
